// File: rtl/sync_fifo_param_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_param_if
// Bundles the producer/consumer side of sync_fifo_param into one interface.
//   master : the user of the FIFO (drives clear, wr_en, wr_data, rd_en)
//   slave  : the FIFO itself (drives rd_data, rd_valid, status flags,
//            count and the overflow/underflow pulses)
// Parameters DATA_WIDTH and DEPTH must match the FIFO instance they connect.
// ----------------------------------------------------------------------------
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  clear;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clear, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// ----------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO with configurable width/depth, standard or
// first-word-fall-through read, programmable almost-full/almost-empty
// thresholds, occupancy count, overflow/underflow pulses and sync flush.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : sync_fifo_param_if.slave (clear, wr_en/wr_data, rd_en,
//            rd_data/rd_valid, full/empty/almost_full/almost_empty,
//            count, overflow/underflow)
// ----------------------------------------------------------------------------
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    sync_fifo_param_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DepthCount = CW'(DEPTH);
    localparam logic [CW-1:0] AfLevel    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeLevel    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]         wrPtr_q, wrPtr_d;
    logic [AW-1:0]         rdPtr_q, rdPtr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
    logic                  rdValid_q, rdValid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  fullNow;
    logic                  emptyNow;
    logic                  rdAcc;
    logic                  wrAcc;

    assign fullNow  = (count_q == DepthCount);
    assign emptyNow = (count_q == '0);

    // A read that pops a word frees a slot in the same cycle, so a write is
    // still accepted when full as long as a read is accepted alongside it.
    assign rdAcc = bus.rd_en & ~emptyNow;
    assign wrAcc = bus.wr_en & (~fullNow | rdAcc);

    // Next-state computation. Flush wins over everything else and leaves
    // rd_data and the memory untouched; the error pulses are also suppressed.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        rdData_d    = rdData_q;
        rdValid_d   = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;

        if (bus.clear) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wrAcc) begin
                wrPtr_d = wrPtr_q + 1'b1;
            end
            if (rdAcc) begin
                rdPtr_d   = rdPtr_q + 1'b1;
                rdData_d  = mem[rdPtr_q];
                rdValid_d = 1'b1;
            end
            overflow_d  = bus.wr_en & ~wrAcc;
            underflow_d = bus.rd_en & emptyNow;

            unique case ({wrAcc, rdAcc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control and read-side registers; all cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            rdData_q    <= '0;
            rdValid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            rdData_q    <= rdData_d;
            rdValid_q   <= rdValid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is deliberately not reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wrAcc && !bus.clear) begin
            mem[wrPtr_q] <= bus.wr_data;
        end
    end

    assign bus.full         = fullNow;
    assign bus.empty        = emptyNow;
    assign bus.almost_full  = (count_q >= AfLevel);
    assign bus.almost_empty = (count_q <= AeLevel);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // In FWFT mode the head word is shown directly. While empty the head
    // entry may never have been written, so the last popped word is shown
    // instead (zero after reset).
    generate
        if (FWFT != 0) begin : gFwft
            assign bus.rd_data  = emptyNow ? rdData_q : mem[rdPtr_q];
            assign bus.rd_valid = ~emptyNow;
        end else begin : gStd
            assign bus.rd_data  = rdData_q;
            assign bus.rd_valid = rdValid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_param
// Drives a standard-mode and an FWFT-mode sync_fifo_param (DEPTH=8,
// DATA_WIDTH=8, AF_THRESH=6, AE_THRESH=2) with identical stimulus and
// compares both against a queue-based reference model.
// ----------------------------------------------------------------------------
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) stdIf ();
    sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fwftIf ();

    sync_fifo_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
    ) dutStd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (stdIf.slave)
    );

    sync_fifo_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
    ) dutFwft (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fwftIf.slave)
    );

    // Reference model state: contents as a queue plus the expected
    // registered outputs of the standard-mode read port.
    logic [7:0] q[$];
    logic [7:0] expRdData;
    bit         expRdValid;
    bit         expOvf;
    bit         expUnf;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        q.delete();
        expRdData  = '0;
        expRdValid = 1'b0;
        expOvf     = 1'b0;
        expUnf     = 1'b0;
    endtask

    // One clock of FIFO behaviour evaluated on the pre-edge contents.
    task automatic modelStep(input bit clr, input bit wr, input logic [7:0] wd, input bit rd);
        bit wasEmpty;
        bit wasFull;
        bit rdOk;
        bit wrOk;
        wasEmpty = (q.size() == 0);
        wasFull  = (q.size() == DEPTH);
        if (clr) begin
            q.delete();
            expRdValid = 1'b0;
            expOvf     = 1'b0;
            expUnf     = 1'b0;
        end else begin
            rdOk   = rd && !wasEmpty;
            wrOk   = wr && (!wasFull || rdOk);
            expOvf = wr && !wrOk;
            expUnf = rd && wasEmpty;
            expRdValid = rdOk;
            if (rdOk) expRdData = q.pop_front();
            if (wrOk) q.push_back(wd);
        end
    endtask

    task automatic checkAll(input string tag);
        int n;
        n = q.size();
        checkOutput({tag, ":std.count"},   32'(stdIf.count),        32'(n));
        checkOutput({tag, ":std.full"},    32'(stdIf.full),         32'(n == DEPTH));
        checkOutput({tag, ":std.empty"},   32'(stdIf.empty),        32'(n == 0));
        checkOutput({tag, ":std.aFull"},   32'(stdIf.almost_full),  32'(n >= AF));
        checkOutput({tag, ":std.aEmpty"},  32'(stdIf.almost_empty), 32'(n <= AE));
        checkOutput({tag, ":std.rdValid"}, 32'(stdIf.rd_valid),     32'(expRdValid));
        checkOutput({tag, ":std.rdData"},  32'(stdIf.rd_data),      32'(expRdData));
        checkOutput({tag, ":std.ovf"},     32'(stdIf.overflow),     32'(expOvf));
        checkOutput({tag, ":std.unf"},     32'(stdIf.underflow),    32'(expUnf));
        checkOutput({tag, ":fwft.count"},   32'(fwftIf.count),      32'(n));
        checkOutput({tag, ":fwft.rdValid"}, 32'(fwftIf.rd_valid),   32'(n != 0));
        if (n != 0) begin
            checkOutput({tag, ":fwft.rdData"}, 32'(fwftIf.rd_data), 32'(q[0]));
        end
        checkOutput({tag, ":fwft.ovf"},     32'(fwftIf.overflow),   32'(expOvf));
        checkOutput({tag, ":fwft.unf"},     32'(fwftIf.underflow),  32'(expUnf));
    endtask

    task automatic driveInputs(input bit clr, input bit wr, input logic [7:0] wd, input bit rd);
        stdIf.clear    = clr;
        stdIf.wr_en    = wr;
        stdIf.wr_data  = wd;
        stdIf.rd_en    = rd;
        fwftIf.clear   = clr;
        fwftIf.wr_en   = wr;
        fwftIf.wr_data = wd;
        fwftIf.rd_en   = rd;
    endtask

    task automatic applyStimulus(input string tag, input bit clr, input bit wr,
                                 input logic [7:0] wd, input bit rd);
        driveInputs(clr, wr, wd, rd);
        @(posedge clk);
        modelStep(clr, wr, wd, rd);
        #1;
        checkAll(tag);
    endtask

    task automatic randomCycles(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(tag, 1'b0, ($urandom_range(0, 99) < 60),
                          8'($urandom), ($urandom_range(0, 99) < 55));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        driveInputs(1'b0, 1'b0, 8'h00, 1'b0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full and watch the threshold flags move
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus("fill", 1'b0, 1'b1, 8'(i * 17), 1'b0);
        end

        // Write while full is dropped and pulses overflow for one cycle
        applyStimulus("ovf", 1'b0, 1'b1, 8'h99, 1'b0);
        applyStimulus("ovfEnd", 1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("drain", 1'b0, 1'b0, 8'h00, 1'b1);
        end
        applyStimulus("drainIdle", 1'b0, 1'b0, 8'h00, 1'b0);

        // Simultaneous read and write while full
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus("refill", 1'b0, 1'b1, 8'(i * 17), 1'b0);
        end
        applyStimulus("passThru", 1'b0, 1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus("passDrain", 1'b0, 1'b0, 8'h00, 1'b1);
        end
        applyStimulus("passIdle", 1'b0, 1'b0, 8'h00, 1'b0);

        // Empty boundary: lone read, then read+write together
        applyStimulus("unfRead", 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("unfIdle", 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus("unfRdWr", 1'b0, 1'b1, 8'h5C, 1'b1);
        applyStimulus("unfGet", 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus("unfIdle2", 1'b0, 1'b0, 8'h00, 1'b0);

        // FWFT: word visible without a read, then popped
        applyStimulus("fwftWr", 1'b0, 1'b1, 8'hA5, 1'b0);
        applyStimulus("fwftPop", 1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic across pointer wrap
        randomCycles("rand", 40);

        // Flush at count 5 together with a write
        for (int i = 0; i < DEPTH && q.size() > 0; i++) begin
            applyStimulus("preClrDrain", 1'b0, 1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus("preClrFill", 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        end
        applyStimulus("clear", 1'b1, 1'b1, 8'h77, 1'b0);
        randomCycles("postClr", 12);

        // Reset in the middle of a burst takes effect without a clock edge
        randomCycles("preRst", 6);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        randomCycles("postRst", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
